tdm_demux1x8: RTL and testbench



---
 rtl/tdm_demux1x8.sv | 100 ++++++++++
 tb/tb_tdm_demux1x8.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux1x8.sv
// Receive-side 1:8 time-slot demultiplexer: steers a serial sample stream into
// eight slot registers aligned by frame_sync and presents each full frame in parallel.
module tdm_demux1x8 #(
  parameter int W           = 1,
  parameter bit STRICT_SYNC = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  input  logic           frame_sync,
  output logic [8*W-1:0] out,
  output logic           out_valid,
  output logic [2:0]     slot,
  output logic           locked,
  output logic           sync_err
);

  typedef enum logic {HUNT = 1'b0, ACTIVE = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [2:0]     slot_q, slot_d;
  logic [W-1:0]   shadow_q [8];
  logic [W-1:0]   shadow_d [8];
  logic [8*W-1:0] out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic           sync_err_q, sync_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= 3'd0;
      shadow_q    <= '{default: '0};
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            shadow_d[0] = in_data;
            slot_d      = 3'd1;
            state_d     = ACTIVE;
          end
        end
        ACTIVE: begin
          if (frame_sync && (slot_q != 3'd0)) begin
            // Early marker: drop the partial frame and restart it with this sample.
            sync_err_d  = 1'b1;
            shadow_d[0] = in_data;
            slot_d      = 3'd1;
          end else if (!frame_sync && (slot_q == 3'd0) && STRICT_SYNC) begin
            sync_err_d = 1'b1;
            slot_d     = 3'd0;
            state_d    = HUNT;
          end else begin
            shadow_d[slot_q] = in_data;
            if (slot_q == 3'd7) begin
              // Last slot bypasses the shadow so the frame is published on this edge.
              for (int k = 0; k < 7; k++) begin
                out_d[k*W +: W] = shadow_q[k];
              end
              out_d[7*W +: W] = in_data;
              out_valid_d     = 1'b1;
              slot_d          = 3'd0;
            end else begin
              slot_d = slot_q + 3'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign slot      = slot_q;
  assign locked    = (state_q == ACTIVE);
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux1x8.sv
// Directed bench for tdm_demux1x8: strict and free-running W=1 instances share one
// stream, a W=4 instance covers wide samples, gaps and asynchronous reset.
module tb_tdm_demux1x8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // W=1 stream, shared by the strict (s) and free-running (f) instances
  logic       iv1 = 1'b0, id1 = 1'b0, fs1 = 1'b0;
  logic [7:0] out_s, out_f;
  logic       ov_s, ov_f, lk_s, lk_f, er_s, er_f;
  logic [2:0] sl_s, sl_f;

  // W=4 stream
  logic        iv4 = 1'b0, fs4 = 1'b0;
  logic [3:0]  id4 = 4'd0;
  logic [31:0] out_w;
  logic        ov_w, lk_w, er_w;
  logic [2:0]  sl_w;

  tdm_demux1x8 #(.W(1), .STRICT_SYNC(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_data(id1), .in_valid(iv1), .frame_sync(fs1),
    .out(out_s), .out_valid(ov_s), .slot(sl_s), .locked(lk_s), .sync_err(er_s));

  tdm_demux1x8 #(.W(1), .STRICT_SYNC(1'b0)) dut_f (
    .clk(clk), .rst_n(rst_n), .in_data(id1), .in_valid(iv1), .frame_sync(fs1),
    .out(out_f), .out_valid(ov_f), .slot(sl_f), .locked(lk_f), .sync_err(er_f));

  tdm_demux1x8 #(.W(4), .STRICT_SYNC(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_data(id4), .in_valid(iv4), .frame_sync(fs4),
    .out(out_w), .out_valid(ov_w), .slot(sl_w), .locked(lk_w), .sync_err(er_w));

  int total = 0;
  int bad   = 0;

  // Pulse counters: sampled on posedge, so they see the value held over the previous cycle.
  int nov_s = 0, nov_f = 0, nov_w = 0, ner_s = 0, ner_f = 0;
  always @(posedge clk) begin
    if (ov_s) nov_s <= nov_s + 1;
    if (ov_f) nov_f <= nov_f + 1;
    if (ov_w) nov_w <= nov_w + 1;
    if (er_s) ner_s <= ner_s + 1;
    if (er_f) ner_f <= ner_f + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on negedge; after a call, outputs reflect the previous posedge.
  task automatic step1(input logic v, input logic d, input logic f);
    @(negedge clk);
    iv1 = v; id1 = d; fs1 = f;
  endtask

  task automatic step4(input logic v, input logic [3:0] d, input logic f);
    @(negedge clk);
    iv4 = v; id4 = d; fs4 = f;
  endtask

  task automatic frame1(input logic [7:0] bits, input logic sync_first);
    for (int k = 0; k < 8; k++) step1(1'b1, bits[k], (k == 0) ? sync_first : 1'b0);
    step1(1'b0, 1'b0, 1'b0);
  endtask

  int b_s, b_f, b_w, e_s, e_f;

  initial begin
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_out", {24'd0, out_s}, 32'd0);
    chk("rst_ov", {31'd0, ov_s}, 32'd0);
    chk("rst_slot", {29'd0, sl_s}, 32'd0);
    chk("rst_lock", {31'd0, lk_s}, 32'd0);
    chk("rst_err", {31'd0, er_s}, 32'd0);
    rst_n = 1'b1;

    // 1: basic frame 1,0,1,1,0,0,1,0
    b_s = nov_s; b_f = nov_f;
    frame1(8'b0100_1101, 1'b1);
    chk("t1_out_s", {24'd0, out_s}, 32'h4D);
    chk("t1_out_f", {24'd0, out_f}, 32'h4D);
    chk("t1_ov", {31'd0, ov_s}, 32'd1);
    chk("t1_slot", {29'd0, sl_s}, 32'd0);
    chk("t1_lock", {31'd0, lk_s}, 32'd1);
    step1(1'b0, 1'b0, 1'b0);
    chk("t1_ov_drop", {31'd0, ov_s}, 32'd0);
    step1(1'b0, 1'b0, 1'b0);
    chk("t1_npulse", nov_s - b_s, 32'd1);

    // 2: back to HUNT, unsynced samples dropped, then 0xA5
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    e_s = ner_s;
    for (int k = 0; k < 3; k++) step1(1'b1, 1'b1, 1'b0);
    step1(1'b0, 1'b0, 1'b0);
    chk("t2_hunt_lock", {31'd0, lk_s}, 32'd0);
    chk("t2_hunt_slot", {29'd0, sl_s}, 32'd0);
    b_s = nov_s;
    frame1(8'hA5, 1'b1);
    chk("t2_out", {24'd0, out_s}, 32'hA5);
    step1(1'b0, 1'b0, 1'b0);
    chk("t2_npulse", nov_s - b_s, 32'd1);
    chk("t2_noerr", ner_s - e_s, 32'd0);

    // 3: frame_sync on slot 4 restarts the frame
    e_s = ner_s;
    step1(1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 4; k++) step1(1'b1, 1'b1, 1'b0);
    step1(1'b0, 1'b0, 1'b0);
    chk("t3_slot4", {29'd0, sl_s}, 32'd4);
    b_s = nov_s;
    frame1(8'h3C, 1'b1);
    // frame1 already ran the full new frame; re-check the pulse at the restart point too
    chk("t3_out", {24'd0, out_s}, 32'h3C);
    step1(1'b0, 1'b0, 1'b0);
    chk("t3_npulse", nov_s - b_s, 32'd1);
    chk("t3_nerr", ner_s - e_s, 32'd1);
    // isolate the restart edge itself
    for (int k = 0; k < 4; k++) step1(1'b1, 1'b0, (k == 0));
    step1(1'b1, 1'b1, 1'b1);
    step1(1'b0, 1'b0, 1'b0);
    chk("t3_err_pulse", {31'd0, er_s}, 32'd1);
    chk("t3_out_hold", {24'd0, out_s}, 32'h3C);
    chk("t3_slot1", {29'd0, sl_s}, 32'd1);
    chk("t3_ov_none", {31'd0, ov_s}, 32'd0);
    b_s = nov_s;
    for (int k = 1; k < 8; k++) step1(1'b1, (k >= 4), 1'b0);
    step1(1'b0, 1'b0, 1'b0);
    chk("t3_out2", {24'd0, out_s}, 32'hF1);
    chk("t3_ov2", {31'd0, ov_s}, 32'd1);
    step1(1'b0, 1'b0, 1'b0);
    chk("t3_npulse2", nov_s - b_s, 32'd1);

    // 4: slot-0 sample without frame_sync, strict vs free-running
    b_s = nov_s; b_f = nov_f; e_f = ner_f;
    step1(1'b1, 1'b1, 1'b0);
    step1(1'b0, 1'b0, 1'b0);
    chk("t4_s_err", {31'd0, er_s}, 32'd1);
    chk("t4_s_lock", {31'd0, lk_s}, 32'd0);
    chk("t4_s_slot", {29'd0, sl_s}, 32'd0);
    chk("t4_f_lock", {31'd0, lk_f}, 32'd1);
    chk("t4_f_slot", {29'd0, sl_f}, 32'd1);
    for (int k = 1; k < 8; k++) step1(1'b1, (k == 7), 1'b0);
    step1(1'b0, 1'b0, 1'b0);
    chk("t4_f_out", {24'd0, out_f}, 32'h81);
    chk("t4_s_out", {24'd0, out_s}, 32'hF1);
    step1(1'b0, 1'b0, 1'b0);
    chk("t4_f_npulse", nov_f - b_f, 32'd1);
    chk("t4_s_npulse", nov_s - b_s, 32'd0);
    chk("t4_f_noerr", ner_f - e_f, 32'd0);

    // 5: W=4 nibbles 0..7 with random gaps
    b_w = nov_w;
    for (int k = 0; k < 8; k++) begin
      step4(1'b1, 4'(k), (k == 0));
      repeat ($urandom_range(0, 3)) step4(1'b0, 4'd0, 1'b0);
    end
    step4(1'b0, 4'd0, 1'b0);
    step4(1'b0, 4'd0, 1'b0);
    chk("t5_out", out_w, 32'h7654_3210);
    chk("t5_npulse", nov_w - b_w, 32'd1);
    chk("t5_noerr", {31'd0, er_w}, 32'd0);

    // 6: asynchronous reset mid-frame
    b_w = nov_w;
    for (int k = 0; k < 5; k++) step4(1'b1, 4'd9, (k == 0));
    step4(1'b0, 4'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out", out_w, 32'd0);
    chk("t6_rst_lock", {31'd0, lk_w}, 32'd0);
    chk("t6_rst_slot", {29'd0, sl_w}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) step4(1'b1, 4'(15 - k), (k == 0));
    step4(1'b0, 4'd0, 1'b0);
    chk("t6_out", out_w, 32'h89AB_CDEF);
    step4(1'b0, 4'd0, 1'b0);
    chk("t6_npulse", nov_w - b_w, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
